fir_line_sequencer: RTL and testbench



---
 rtl/fir_seq_pkg.sv | 40 ++++
 rtl/fir_line_sequencer_if.sv | 28 ++
 rtl/fir_seq_rd_pipe.sv | 35 +++
 rtl/fir_line_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_fir_line_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the chroma FIR line sequencer.
// Each pixel pair takes six phases. Lead reads are tagged so that their delayed strobes can be decoded.
package fir_seq_pkg;

  localparam int ADDR_W = 18;
  localparam int PHASES = 6;
  localparam int PH_U   = 0;
  localparam int PH_V   = 3;
  localparam int PH_OUT = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_RUN,
    S_TAIL,
    S_ROW_END,
    S_DONE
  } fir_seq_state_t;

  // Order matches lead read slot 0..3, so a slot index casts directly to its strobe
  typedef enum logic [1:0] {
    K_RD_U0,
    K_RD_V0,
    K_EN_U,
    K_EN_V
  } fir_seq_kind_t;

  typedef struct packed {
    fir_seq_kind_t kind;
    logic          vld;
  } rd_tag_t;

  function automatic logic [ADDR_W-1:0] fir_seq_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [7:0]        row,
                                                     input logic [6:0]        col,
                                                     input int                words);
    return base + ADDR_W'(row) * ADDR_W'(words) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/fir_line_sequencer_if.sv
// Bus between the sequencer and the FIR datapath / SRAM address mux.
// The master drives the read address, the read request and all FIR control strobes.
interface fir_line_sequencer_if
  import fir_seq_pkg::*;
();

  logic [ADDR_W-1:0] SRAM_address;
  logic              SRAM_rd_req;
  logic              line_start;
  logic              line_end;
  logic              read_U_0;
  logic              read_V_0;
  logic              enable_U;
  logic              enable_V;
  logic              cycle;
  logic              pair_valid;

  modport master (
    output SRAM_address, SRAM_rd_req, line_start, line_end,
           read_U_0, read_V_0, enable_U, enable_V, cycle, pair_valid
  );

  modport slave (
    input  SRAM_address, SRAM_rd_req, line_start, line_end,
           read_U_0, read_V_0, enable_U, enable_V, cycle, pair_valid
  );

endinterface

// File: rtl/fir_seq_rd_pipe.sv
// Delays lead-read tags by LAT cycles so each strobe lines up with its SRAM data.
// Reset flushes the pipe, so no strobe can come from a read issued before reset.
module fir_seq_rd_pipe
  import fir_seq_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic          CLOCK_50_I,
  input  logic          resetn,
  input  logic          push_vld_i,
  input  fir_seq_kind_t push_kind_i,
  output logic          pop_vld_o,
  output fir_seq_kind_t pop_kind_o
);

  rd_tag_t tag_q [LAT];

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0].kind <= push_kind_i;
      tag_q[0].vld  <= push_vld_i;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign pop_vld_o  = tag_q[LAT-1].vld;
  assign pop_kind_o = tag_q[LAT-1].kind;

endmodule

// File: rtl/fir_line_sequencer.sv
// Per-row read and strobe sequencer for the chroma upsampling FIR. Each row runs lead, run, tail, then row end.
// Macro FIR_SEQ_ROWCHK_EN adds err_sticky, which latches if a row's read or pair count is wrong.
module fir_line_sequencer
  import fir_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] U_BASE        = 18'd38400,
  parameter logic [ADDR_W-1:0] V_BASE        = 18'd57600,
  parameter int                WORDS_PER_ROW = 80,
  parameter int                ROWS          = 240,
  parameter int                SRAM_LAT      = 2,
  parameter int                TAIL_PAIRS    = 3
) (
  input  logic                        CLOCK_50_I,
  input  logic                        resetn,
  input  logic                        start,
  fir_line_sequencer_if.master        seq_if,
  output logic [7:0]                  row,
  output logic                        busy,
  output logic                        done
`ifdef FIR_SEQ_ROWCHK_EN
  ,
  output logic                        err_sticky
`endif
);

  localparam int LEAD_LEN  = 4 + SRAM_LAT;
  localparam int ROW_PAIRS = 2 * WORDS_PER_ROW;
  localparam int RUN_PAIRS = ROW_PAIRS - TAIL_PAIRS;
  localparam int PH_RD_U   = PHASES - SRAM_LAT;
  localparam int PH_RD_V   = PH_V - SRAM_LAT;

  fir_seq_state_t state_q, state_d;
  logic [7:0]     row_q, row_d;
  logic [6:0]     col_q, col_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     pair_q, pair_d;

  logic           rd_req, rd_is_v;
  logic           push_vld;
  fir_seq_kind_t  push_kind;
  logic           pop_vld;
  fir_seq_kind_t  pop_kind;
  logic           ls, le, en_u_run, en_v_run, cyc, pv, busy_c, done_c;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    pair_d    = pair_q;
    rd_req    = 1'b0;
    rd_is_v   = 1'b0;
    push_vld  = 1'b0;
    push_kind = K_RD_U0;
    ls        = 1'b0;
    le        = 1'b0;
    en_u_run  = 1'b0;
    en_v_run  = 1'b0;
    cyc       = 1'b0;
    pv        = 1'b0;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (start) begin
          state_d = S_LEAD;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LEAD: begin
        ls    = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q < 4'd4) begin
          rd_req    = 1'b1;
          rd_is_v   = cnt_q[0];
          push_vld  = 1'b1;
          push_kind = fir_seq_kind_t'(cnt_q[1:0]);
          if (cnt_q[0]) col_d = col_q + 7'd1;
        end else if (cnt_q == 4'(LEAD_LEN - SRAM_LAT) && col_q < 7'(WORDS_PER_ROW)) begin
          // High byte for run pair 0 must already be on the bus at its first phase
          rd_req = 1'b1;
        end
        if (cnt_q == 4'(LEAD_LEN - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          pair_d  = '0;
        end
      end
      S_RUN, S_TAIL: begin
        le       = (state_q == S_TAIL);
        cyc      = pair_q[0];
        en_u_run = (cnt_q == 4'(PH_U));
        en_v_run = (cnt_q == 4'(PH_V));
        pv       = (cnt_q == 4'(PH_OUT));
        if (state_q == S_RUN && col_q < 7'(WORDS_PER_ROW)) begin
          if (!pair_q[0] && cnt_q == 4'(PH_RD_V)) begin
            rd_req  = 1'b1;
            rd_is_v = 1'b1;
            col_d   = col_q + 7'd1;
          end else if (pair_q[0] && cnt_q == 4'(PH_RD_U)) begin
            rd_req = 1'b1;
          end
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(PHASES - 1)) begin
          cnt_d  = '0;
          pair_d = pair_q + 8'd1;
          if (pair_q == 8'(RUN_PAIRS - 1)) state_d = S_TAIL;
          if (pair_q == 8'(ROW_PAIRS - 1)) state_d = S_ROW_END;
        end
      end
      S_ROW_END: begin
        if (row_q < 8'(ROWS - 1)) begin
          row_d   = row_q + 8'd1;
          col_d   = '0;
          cnt_d   = '0;
          state_d = S_LEAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_c  = 1'b0;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  fir_seq_rd_pipe #(.LAT(SRAM_LAT)) u_rd_pipe (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .push_vld_i (push_vld),
    .push_kind_i(push_kind),
    .pop_vld_o  (pop_vld),
    .pop_kind_o (pop_kind)
  );

  assign seq_if.SRAM_rd_req  = rd_req;
  assign seq_if.SRAM_address = rd_req ? fir_seq_addr(rd_is_v ? V_BASE : U_BASE, row_q, col_q, WORDS_PER_ROW)
                                      : '0;
  assign seq_if.line_start   = ls;
  assign seq_if.line_end     = le;
  assign seq_if.read_U_0     = pop_vld && (pop_kind == K_RD_U0);
  assign seq_if.read_V_0     = pop_vld && (pop_kind == K_RD_V0);
  assign seq_if.enable_U     = en_u_run | (pop_vld && (pop_kind == K_EN_U));
  assign seq_if.enable_V     = en_v_run | (pop_vld && (pop_kind == K_EN_V));
  assign seq_if.cycle        = cyc;
  assign seq_if.pair_valid   = pv;

  assign row  = row_q;
  assign busy = busy_c;
  assign done = done_c;

`ifdef FIR_SEQ_ROWCHK_EN
  logic [7:0] n_rd_u_q, n_rd_v_q;
  logic [8:0] n_pv_q;
  logic       err_q;

  // The tallies watch the bus itself, so they also catch a request lost downstream of the FSM
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      n_rd_u_q <= '0;
      n_rd_v_q <= '0;
      n_pv_q   <= '0;
      err_q    <= 1'b0;
    end else if (state_q == S_ROW_END || state_q == S_IDLE) begin
      n_rd_u_q <= '0;
      n_rd_v_q <= '0;
      n_pv_q   <= '0;
      if (state_q == S_ROW_END &&
          (n_rd_u_q != 8'(WORDS_PER_ROW) || n_rd_v_q != 8'(WORDS_PER_ROW) ||
           n_pv_q != 9'(ROW_PAIRS))) begin
        err_q <= 1'b1;
      end
    end else begin
      if (seq_if.SRAM_rd_req && !rd_is_v) n_rd_u_q <= n_rd_u_q + 8'd1;
      if (seq_if.SRAM_rd_req &&  rd_is_v) n_rd_v_q <= n_rd_v_q + 8'd1;
      if (seq_if.pair_valid)              n_pv_q   <= n_pv_q + 9'd1;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_fir_line_sequencer.sv
// Randomised bench for fir_line_sequencer on a 2-row frame with default row geometry.
// Expected per-cycle strobes and addresses come from row/pair/phase arithmetic.
`timescale 1ns/1ps
module tb_fir_line_sequencer;

  localparam int ROWS_TB = 2;
  localparam int W       = 80;
  localparam int LAT     = 2;
  localparam int LEAD    = 4 + LAT;
  localparam int PAIRS   = 2 * W;
  localparam int TAIL    = 3;
  localparam int ROW_CYC = LEAD + 6 * PAIRS + 1;
  localparam int U_B     = 38400;
  localparam int V_B     = 57600;

  logic       CLOCK_50_I = 1'b0;
  logic       resetn     = 1'b0;
  logic       start      = 1'b0;
  logic [7:0] row;
  logic       busy, done;
`ifdef FIR_SEQ_ROWCHK_EN
  logic       err_sticky;
`endif

  fir_line_sequencer_if bus_if();

  fir_line_sequencer #(.ROWS(ROWS_TB)) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .start     (start),
    .seq_if    (bus_if),
    .row       (row),
    .busy      (busy),
    .done      (done)
`ifdef FIR_SEQ_ROWCHK_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] obs_strb();
    return {bus_if.line_start, bus_if.line_end, bus_if.read_U_0, bus_if.read_V_0,
            bus_if.enable_U, bus_if.enable_V, bus_if.cycle, bus_if.pair_valid, bus_if.SRAM_rd_req};
  endfunction

  function automatic logic [63:0] obs_all();
    return {27'd0, done, busy, row, obs_strb(), bus_if.SRAM_address};
  endfunction

  // Expected bus for cycle t of row r (t = 0 is the first lead cycle, ROW_CYC-1 is row end)
  function automatic logic [63:0] exp_vec(input int r, input int t);
    logic ls, le, ru, rv, eu, ev, cy, pv, rd;
    logic [17:0] a;
    int q, p, ph;
    {ls, le, ru, rv, eu, ev, cy, pv, rd} = '0;
    a = '0;
    if (t < LEAD) begin
      ls = 1'b1;
      if (t < 4) begin
        rd = 1'b1;
        a  = 18'(((t % 2 == 0) ? U_B : V_B) + r * W + t / 2);
      end
      ru = (t == 0 + LAT);
      rv = (t == 1 + LAT);
      eu = (t == 2 + LAT);
      ev = (t == 3 + LAT);
    end else if (t < ROW_CYC - 1) begin
      q  = t - LEAD;
      p  = q / 6;
      ph = q % 6;
      eu = (ph == 0);
      ev = (ph == 3);
      cy = p[0];
      pv = (ph == 5);
      le = (p >= PAIRS - TAIL);
    end
    // Word c >= 2 feeds even pair 2(c-2): U data due at its phase 0, V data at phase 3
    for (int c = 2; c < W; c++) begin
      if (t == LEAD + 12 * (c - 2) - LAT) begin
        rd = 1'b1;
        a  = 18'(U_B + r * W + c);
      end
      if (t == LEAD + 12 * (c - 2) + 3 - LAT) begin
        rd = 1'b1;
        a  = 18'(V_B + r * W + c);
      end
    end
    return {27'd0, 1'b0, 1'b1, 8'(r), ls, le, ru, rv, eu, ev, cy, pv, rd, a};
  endfunction

  task automatic pulse_start();
    @(negedge CLOCK_50_I);
    start = 1'b1;
    @(negedge CLOCK_50_I);
    start = 1'b0;
  endtask

  task automatic run_frame(input bit spur);
    int n_u, n_v, n_pv, n_le;
    pulse_start();
    for (int r = 0; r < ROWS_TB; r++) begin
      n_u = 0; n_v = 0; n_pv = 0; n_le = 0;
      for (int t = 0; t < ROW_CYC; t++) begin
        chk("cyc", obs_all(), exp_vec(r, t));
        if (bus_if.SRAM_rd_req && bus_if.SRAM_address <  18'(V_B)) n_u++;
        if (bus_if.SRAM_rd_req && bus_if.SRAM_address >= 18'(V_B)) n_v++;
        if (bus_if.pair_valid) n_pv++;
        if (bus_if.line_end)   n_le++;
        start = spur && ($urandom_range(0, 31) == 0);
        @(negedge CLOCK_50_I);
      end
      chk("row_u_reads", 64'(n_u), 64'(W));
      chk("row_v_reads", 64'(n_v), 64'(W));
      chk("row_pairs", 64'(n_pv), 64'(PAIRS));
      chk("row_line_end", 64'(n_le), 64'(6 * TAIL));
    end
    start = 1'b0;
    chk("done_busy", {62'd0, done, busy}, 64'd2);
    chk("done_strb", 64'(obs_strb()), 64'd0);
    @(negedge CLOCK_50_I);
    chk("after_done", {62'd0, done, busy}, 64'd0);
  endtask

  // Abort row 0 at cycle stop_t with an async reset; nothing may strobe afterwards
  task automatic reset_mid(input int stop_t);
    pulse_start();
    for (int t = 0; t < stop_t; t++) begin
      chk("pre_rst", obs_all(), exp_vec(0, t));
      @(negedge CLOCK_50_I);
    end
    resetn = 1'b0;
    #1;
    chk("in_rst", obs_all(), 64'd0);
    repeat (2) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50_I);
      chk("post_rst", obs_all(), 64'd0);
    end
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge CLOCK_50_I);
    chk("reset", obs_all(), 64'd0);
    resetn = 1'b1;
    repeat ($urandom_range(2, 6)) begin
      @(negedge CLOCK_50_I);
      chk("idle", obs_all(), 64'd0);
    end
`ifdef FIR_SEQ_ROWCHK_EN
    chk("err_reset", 64'(err_sticky), 64'd0);
`endif

    run_frame(1'b0);
    repeat ($urandom_range(1, 5)) @(negedge CLOCK_50_I);
    run_frame(1'b1);

    reset_mid(($urandom_range(0, 1) != 0) ? 3 : 5);
    run_frame(1'b1);

    reset_mid($urandom_range(LEAD, ROW_CYC - 1));
    repeat ($urandom_range(0, 4)) @(negedge CLOCK_50_I);
    run_frame(1'b1);

`ifdef FIR_SEQ_ROWCHK_EN
    chk("err_clean", 64'(err_sticky), 64'd0);
    pulse_start();
    for (int r = 0; r < ROWS_TB; r++) begin
      for (int t = 0; t < ROW_CYC; t++) begin
        if (r == 0 && t == 1) force bus_if.SRAM_rd_req = 1'b0;
        if (r == 0 && t == 2) release bus_if.SRAM_rd_req;
        if (r == 0 && t == ROW_CYC - 1) chk("err_before_end", 64'(err_sticky), 64'd0);
        if (r == 1 && t == 0) chk("err_set", 64'(err_sticky), 64'd1);
        @(negedge CLOCK_50_I);
      end
    end
    repeat (3) @(negedge CLOCK_50_I);
    chk("err_held", 64'(err_sticky), 64'd1);
    resetn = 1'b0;
    #1;
    chk("err_cleared", 64'(err_sticky), 64'd0);
    @(negedge CLOCK_50_I);
    resetn = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
